pe_dbw: RTL and testbench

Next-generation weight-stationary processing element for the INT8 systolic array, parametrised in operand and accumulator width. It adds a shadow weight register so the next tile's weights can be loaded while the current tile computes. It also adds a signed/unsigned activation mode, a registered multiply stage, a saturating accumulator with a sticky overflow flag, and a result shift chain for draining the column without a wide mux. One instance sits at every array node. Activations flow west→east; weights, load strobes and drained results flow north→south.

---
 rtl/pe_dbw.sv | 161 ++++++++++++++++
 tb/tb_pe_dbw.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_dbw.sv
// pe_dbw -- weight-stationary processing element for the INT8 systolic array.
//
// Holds a double-buffered weight (shadow + active) so the next tile's weights
// can be loaded while the current tile computes. Each enabled cycle it
// multiplies the activation by the active weight into a registered product
// stage, then accumulates into a saturating (or wrapping) accumulator with a
// sticky overflow flag. A per-PE drain register forms a shift chain so a whole
// column can be read out from the southmost PE without a wide mux.
//
// Parameters:
//   A_W    activation width
//   W_W    weight width (weights are always signed)
//   ACC_W  accumulator width, at least A_W+W_W+1
//   PIPE   1 = registered a_out, 0 = combinational pass-through
//   SAT    1 = saturating accumulate, 0 = two's-complement wrap
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   a_in, a_signed   activation from the west and its signedness (used with en)
//   a_out            activation forwarded east
//   b_in, load_weight    weight from the north and its shadow-load strobe
//   b_out, load_weight_out  registered copies forwarded south
//   swap             copy shadow weight into the active weight
//   en               MAC enable
//   clr              synchronous accumulator and overflow clear
//   acc, ovf         accumulator value and sticky overflow flag
//   cap, shift       drain control: capture acc, or shift in acc_in
//   acc_in, acc_out  drain chain from the north neighbour / to the south

module pe_dbw #(
  parameter int A_W   = 8,
  parameter int W_W   = 8,
  parameter int ACC_W = 32,
  parameter int PIPE  = 1,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [A_W-1:0]   a_in,
  input  logic             a_signed,
  output logic [A_W-1:0]   a_out,
  input  logic [W_W-1:0]   b_in,
  input  logic             load_weight,
  output logic [W_W-1:0]   b_out,
  output logic             load_weight_out,
  input  logic             swap,
  input  logic             en,
  input  logic             clr,
  output logic [ACC_W-1:0] acc,
  output logic             ovf,
  input  logic             cap,
  input  logic             shift,
  input  logic [ACC_W-1:0] acc_in,
  output logic [ACC_W-1:0] acc_out
);

  localparam int P_W = A_W + W_W + 1;

  logic [W_W-1:0]   w_active;
  logic [W_W-1:0]   w_shadow;
  logic [A_W:0]     a_ext;
  logic [P_W-1:0]   a_wide;
  logic [P_W-1:0]   w_wide;
  logic [P_W-1:0]   prod;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] p_reg;
  logic             p_vld;
  logic [ACC_W:0]   sum;
  logic             pos_ovf;
  logic             neg_ovf;
  logic [ACC_W-1:0] acc_next;

  // Activation forwarding east: registered or a plain wire.
  if (PIPE != 0) begin : g_pipe
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) a_out <= '0;
      else        a_out <= a_in;
    end
  end else begin : g_comb
    assign a_out = a_in;
  end

  // Weight double buffer and southward propagation. On a simultaneous
  // load+swap the active weight takes the old shadow value, which falls out
  // of the non-blocking update order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_shadow        <= '0;
      w_active        <= '0;
      b_out           <= '0;
      load_weight_out <= 1'b0;
    end else begin
      if (load_weight) w_shadow <= b_in;
      if (swap)        w_active <= w_shadow;
      b_out           <= b_in;
      load_weight_out <= load_weight;
    end
  end

  // The extra top bit lets an unsigned activation become a non-negative
  // signed value. Both operands are sign-extended to the full product width
  // so the low P_W bits of the multiply are the exact signed product.
  assign a_ext  = {a_signed & a_in[A_W-1], a_in};
  assign a_wide = {{W_W{a_ext[A_W]}}, a_ext};
  assign w_wide = {{(A_W+1){w_active[W_W-1]}}, w_active};
  assign prod   = $signed(a_wide) * $signed(w_wide);

  if (ACC_W > P_W) begin : g_ext
    assign prod_ext = {{(ACC_W-P_W){prod[P_W-1]}}, prod};
  end else begin : g_noext
    assign prod_ext = prod;
  end

  // Registered multiply stage; the product only needs to move when a MAC
  // is requested since p_vld gates its use downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg <= '0;
      p_vld <= 1'b0;
    end else begin
      if (en) p_reg <= prod_ext;
      p_vld <= en;
    end
  end

  // One extra bit of headroom: the top two sum bits disagreeing means the
  // signed result no longer fits in ACC_W bits.
  assign sum     = {acc[ACC_W-1], acc} + {p_reg[ACC_W-1], p_reg};
  assign pos_ovf = ~sum[ACC_W] &  sum[ACC_W-1];
  assign neg_ovf =  sum[ACC_W] & ~sum[ACC_W-1];

  always_comb begin
    acc_next = sum[ACC_W-1:0];
    if (SAT != 0) begin
      if (pos_ovf)      acc_next = {1'b0, {(ACC_W-1){1'b1}}};
      else if (neg_ovf) acc_next = {1'b1, {(ACC_W-1){1'b0}}};
    end
  end

  // Accumulator: clr wins and throws away whatever product is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (p_vld) begin
      acc <= acc_next;
      if (pos_ovf || neg_ovf) ovf <= 1'b1;
    end
  end

  // Drain register: capture wins over shift, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     acc_out <= '0;
    else if (cap)   acc_out <= acc;
    else if (shift) acc_out <= acc_in;
  end

endmodule

// File: tb/tb_pe_dbw.sv
// tb_pe_dbw -- directed bench for pe_dbw.
//
// A 3-PE column (ACC_W=20, saturating, registered a_out) exercises weight
// propagation, MAC timing, double buffering, saturation and the drain chain.
// A fourth standalone PE (wrapping, combinational a_out) shares the top PE's
// inputs so wrap-around arithmetic and the pass-through path are covered too.

module tb_pe_dbw;

  localparam int ACC_W = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [7:0]       a0, a1, a2;
  logic             a_signed;
  logic [7:0]       b_top;
  logic             lw_top, swap, en, clr, cap, shift;
  logic [ACC_W-1:0] acc_top_in;

  logic [7:0]       a_out0, a_out1, a_out2, aw_out;
  logic [7:0]       b_out0, b_out1, b_out2, bw_out;
  logic             lwo0, lwo1, lwo2, lwow;
  logic [ACC_W-1:0] acc0, acc1, acc2, accw;
  logic             ovf0, ovf1, ovf2, ovfw;
  logic [ACC_W-1:0] dr0, dr1, dr2, drw;

  int pass_count = 0;
  int check_count = 0;

  pe_dbw #(.A_W(8), .W_W(8), .ACC_W(ACC_W), .PIPE(1), .SAT(1)) u_pe0 (
    .clk(clk), .rst_n(rst_n), .a_in(a0), .a_signed(a_signed), .a_out(a_out0),
    .b_in(b_top), .load_weight(lw_top), .b_out(b_out0), .load_weight_out(lwo0),
    .swap(swap), .en(en), .clr(clr), .acc(acc0), .ovf(ovf0),
    .cap(cap), .shift(shift), .acc_in(acc_top_in), .acc_out(dr0));

  pe_dbw #(.A_W(8), .W_W(8), .ACC_W(ACC_W), .PIPE(1), .SAT(1)) u_pe1 (
    .clk(clk), .rst_n(rst_n), .a_in(a1), .a_signed(a_signed), .a_out(a_out1),
    .b_in(b_out0), .load_weight(lwo0), .b_out(b_out1), .load_weight_out(lwo1),
    .swap(swap), .en(en), .clr(clr), .acc(acc1), .ovf(ovf1),
    .cap(cap), .shift(shift), .acc_in(dr0), .acc_out(dr1));

  pe_dbw #(.A_W(8), .W_W(8), .ACC_W(ACC_W), .PIPE(1), .SAT(1)) u_pe2 (
    .clk(clk), .rst_n(rst_n), .a_in(a2), .a_signed(a_signed), .a_out(a_out2),
    .b_in(b_out1), .load_weight(lwo1), .b_out(b_out2), .load_weight_out(lwo2),
    .swap(swap), .en(en), .clr(clr), .acc(acc2), .ovf(ovf2),
    .cap(cap), .shift(shift), .acc_in(dr1), .acc_out(dr2));

  pe_dbw #(.A_W(8), .W_W(8), .ACC_W(ACC_W), .PIPE(0), .SAT(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .a_in(a0), .a_signed(a_signed), .a_out(aw_out),
    .b_in(b_top), .load_weight(lw_top), .b_out(bw_out), .load_weight_out(lwow),
    .swap(swap), .en(en), .clr(clr), .acc(accw), .ovf(ovfw),
    .cap(cap), .shift(shift), .acc_in(acc_top_in), .acc_out(drw));

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  // Drives the top activation, en and clr, then lets one rising edge pass.
  task automatic applyStimulus(input logic [7:0] av, input logic env, input logic clrv);
    a0  = av;
    en  = env;
    clr = clrv;
    @(negedge clk);
  endtask

  // Loads the shadow weight down the whole column, then swaps it active.
  task automatic loadWeights(input logic [7:0] w);
    b_top  = w;
    lw_top = 1'b1;
    repeat (3) @(negedge clk);
    lw_top = 1'b0;
    swap   = 1'b1;
    @(negedge clk);
    swap   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; a0 = '0; a1 = '0; a2 = '0; a_signed = 1'b1;
    b_top = '0; lw_top = 1'b0; swap = 1'b0; en = 1'b0; clr = 1'b0;
    cap = 1'b0; shift = 1'b0; acc_top_in = '0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_acc", $signed(acc0), 0);
    checkOutput("rst_ovf", ovf0, 0);
    checkOutput("rst_drain", $signed(dr2), 0);
    checkOutput("rst_b_out", b_out0, 0);
    checkOutput("rst_a_out", a_out0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Activation forwarding: combinational vs registered
    a0 = 8'h5A;
    #1;
    checkOutput("a_out_comb", aw_out, 8'h5A);
    checkOutput("a_out_reg_before", a_out0, 0);
    @(negedge clk);
    checkOutput("a_out_reg_after", a_out0, 8'h5A);

    // Weight -3 loaded by hand to watch b_out/load_weight_out latency
    b_top = 8'hFD; lw_top = 1'b1;
    @(negedge clk);
    checkOutput("b_out0_lat", b_out0, 8'hFD);
    checkOutput("lwo0_lat", lwo0, 1);
    checkOutput("b_out1_lat", b_out1, 0);
    repeat (2) @(negedge clk);
    lw_top = 1'b0; swap = 1'b1;
    @(negedge clk);
    swap = 1'b0;
    checkOutput("b_out2_lat", b_out2, 8'hFD);

    // Signed MAC: -3 * (5, -7, 127) = -375
    applyStimulus(8'd5, 1'b1, 1'b0);
    checkOutput("mac_lat0", $signed(acc0), 0);
    applyStimulus(8'hF9, 1'b1, 1'b0);
    checkOutput("mac_lat1", $signed(acc0), -15);
    applyStimulus(8'd127, 1'b1, 1'b0);
    applyStimulus(8'd0, 1'b0, 1'b0);
    checkOutput("mac_signed", $signed(acc0), -375);
    checkOutput("mac_signed_ovf", ovf0, 0);
    checkOutput("mac_wrap_inst", $signed(accw), -375);

    // Unsigned vs signed activation with weight 2
    loadWeights(8'd2);
    a_signed = 1'b0;
    applyStimulus(8'd0, 1'b0, 1'b1);
    applyStimulus(8'hFF, 1'b1, 1'b0);
    applyStimulus(8'd0, 1'b0, 1'b0);
    checkOutput("unsigned_ff", $signed(acc0), 510);
    a_signed = 1'b1;
    applyStimulus(8'd0, 1'b0, 1'b1);
    applyStimulus(8'hFF, 1'b1, 1'b0);
    applyStimulus(8'd0, 1'b0, 1'b0);
    checkOutput("signed_ff", $signed(acc0), -2);

    // Double buffer: products up to the swap edge use 4, later ones 9
    loadWeights(8'd4);
    applyStimulus(8'd0, 1'b0, 1'b1);
    applyStimulus(8'd1, 1'b1, 1'b0);
    b_top = 8'd9; lw_top = 1'b1;
    applyStimulus(8'd1, 1'b1, 1'b0);
    lw_top = 1'b0; swap = 1'b1;
    applyStimulus(8'd1, 1'b1, 1'b0);
    swap = 1'b0;
    applyStimulus(8'd1, 1'b1, 1'b0);
    checkOutput("dbuf_pre_swap", $signed(acc0), 12);
    applyStimulus(8'd1, 1'b1, 1'b0);
    applyStimulus(8'd0, 1'b0, 1'b0);
    checkOutput("dbuf_total", $signed(acc0), 30);

    // Simultaneous load 6 + swap: active keeps old shadow 9, shadow gets 6
    b_top = 8'd6; lw_top = 1'b1; swap = 1'b1;
    applyStimulus(8'd0, 1'b0, 1'b1);
    lw_top = 1'b0; swap = 1'b0;
    applyStimulus(8'd1, 1'b1, 1'b0);
    applyStimulus(8'd0, 1'b0, 1'b0);
    checkOutput("dbuf_sim_active", $signed(acc0), 9);
    swap = 1'b1;
    applyStimulus(8'd0, 1'b0, 1'b0);
    swap = 1'b0;
    applyStimulus(8'd1, 1'b1, 1'b1);
    applyStimulus(8'd0, 1'b0, 1'b0);
    checkOutput("dbuf_sim_shadow", $signed(acc0), 6);

    // clr+en starts fresh: 100 then clr+en with 2*3 gives 6
    loadWeights(8'd10);
    applyStimulus(8'd0, 1'b0, 1'b1);
    applyStimulus(8'd10, 1'b1, 1'b0);
    applyStimulus(8'd0, 1'b0, 1'b0);
    checkOutput("acc_100", $signed(acc0), 100);
    loadWeights(8'd3);
    checkOutput("acc_hold", $signed(acc0), 100);
    applyStimulus(8'd2, 1'b1, 1'b1);
    applyStimulus(8'd0, 1'b0, 1'b0);
    checkOutput("clr_en", $signed(acc0), 6);

    // A product in flight during clr is discarded
    applyStimulus(8'd2, 1'b1, 1'b0);
    applyStimulus(8'd0, 1'b0, 1'b1);
    applyStimulus(8'd0, 1'b0, 1'b0);
    checkOutput("clr_discard", $signed(acc0), 0);

    // Positive saturation: 40 x (+16384)
    loadWeights(8'h80);
    applyStimulus(8'd0, 1'b0, 1'b1);
    repeat (40) applyStimulus(8'h80, 1'b1, 1'b0);
    applyStimulus(8'd0, 1'b0, 1'b0);
    checkOutput("sat_pos", $signed(acc0), 524287);
    checkOutput("sat_pos_ovf", ovf0, 1);
    checkOutput("wrap_pos", $signed(accw), -393216);
    checkOutput("wrap_pos_ovf", ovfw, 1);
    applyStimulus(8'd0, 1'b0, 1'b1);
    checkOutput("sat_clr_acc", $signed(acc0), 0);
    checkOutput("sat_clr_ovf", ovf0, 0);
    checkOutput("wrap_clr_ovf", ovfw, 0);

    // Negative saturation: 40 x (-16256)
    repeat (40) applyStimulus(8'h7F, 1'b1, 1'b0);
    applyStimulus(8'd0, 1'b0, 1'b0);
    checkOutput("sat_neg", $signed(acc0), -524288);
    checkOutput("sat_neg_ovf", ovf0, 1);
    checkOutput("wrap_neg", $signed(accw), 398336);

    // Drain: accs 10, 20, 30 read bottom-first
    loadWeights(8'd10);
    applyStimulus(8'd0, 1'b0, 1'b1);
    a1 = 8'd2; a2 = 8'd3;
    applyStimulus(8'd1, 1'b1, 1'b0);
    a1 = 8'd0; a2 = 8'd0;
    applyStimulus(8'd0, 1'b0, 1'b0);
    checkOutput("col_acc1", $signed(acc1), 20);
    checkOutput("col_acc2", $signed(acc2), 30);
    cap = 1'b1;
    applyStimulus(8'd0, 1'b0, 1'b0);
    cap = 1'b0;
    checkOutput("drain_cap", $signed(dr2), 30);
    applyStimulus(8'd0, 1'b0, 1'b0);
    checkOutput("drain_hold", $signed(dr2), 30);
    shift = 1'b1;
    applyStimulus(8'd0, 1'b0, 1'b0);
    checkOutput("drain_shift1", $signed(dr2), 20);
    applyStimulus(8'd0, 1'b0, 1'b0);
    checkOutput("drain_shift2", $signed(dr2), 10);
    applyStimulus(8'd0, 1'b0, 1'b0);
    checkOutput("drain_shift3", $signed(dr2), 0);
    shift = 1'b0;

    // cap excludes the product accumulating on the same edge
    applyStimulus(8'd1, 1'b1, 1'b0);
    cap = 1'b1;
    applyStimulus(8'd0, 1'b0, 1'b0);
    cap = 1'b0;
    checkOutput("cap_excl_drain", $signed(dr0), 10);
    checkOutput("cap_excl_acc", $signed(acc0), 20);

    // Asynchronous reset in the middle of a shift
    b_top = 8'd5; cap = 1'b1;
    applyStimulus(8'h33, 1'b0, 1'b0);
    cap = 1'b0; shift = 1'b1;
    applyStimulus(8'h33, 1'b0, 1'b0);
    checkOutput("pre_rst_drain", $signed(dr2), 20);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_acc", $signed(acc0), 0);
    checkOutput("async_acc2", $signed(acc2), 0);
    checkOutput("async_drain", $signed(dr2), 0);
    checkOutput("async_a_out", a_out0, 0);
    checkOutput("async_b_out", b_out0, 0);
    shift = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
